// File: rtl/key_repeater.sv
// key_repeater: edge detector plus hold-to-repeat step generator.
// Optional auto-repeat: define KEY_REPEATER_AUTOREPEAT_EN.
module key_repeater #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst_a_p,
    input  logic btn_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic step_pulse,
    output logic held
);

    // Reject timing parameters too short for the counter scheme.
    if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
        $error("key_repeater: HOLD_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    logic btn_q;
    logic press_q;
    logic release_q;
    logic step_q;
    logic press;

    assign press = btn_in & ~btn_q;

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign step_pulse    = step_q;

`ifdef KEY_REPEATER_AUTOREPEAT_EN

    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                        : REPEAT_CYCLES;
    localparam int CW = $clog2(MAXC);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        REPEAT
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          held_q;

    assign held = held_q;

    // Press/hold/repeat sequencer; every output is a register.
    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            btn_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            step_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            btn_q     <= btn_in;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            step_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (press) begin
                        press_q <= 1'b1;
                        step_q  <= 1'b1;
                        state_q <= PRESSED;
                    end
                end
                PRESSED: begin
                    // Release beats a simultaneous terminal count.
                    if (!btn_in) begin
                        release_q <= 1'b1;
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        held_q    <= 1'b0;
                    end else if (cnt_q == HOLD_LAST) begin
                        step_q  <= 1'b1;
                        state_q <= REPEAT;
                        cnt_q   <= '0;
                        held_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!btn_in) begin
                        release_q <= 1'b1;
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        held_q    <= 1'b0;
                    end else if (cnt_q == REP_LAST) begin
                        step_q <= 1'b1;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

`else

    typedef enum logic {
        IDLE,
        PRESSED
    } state_t;

    state_t state_q;

    assign held = 1'b0;

    // Press/release tracker; one step per press, no repeat.
    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            state_q   <= IDLE;
            btn_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            btn_q     <= btn_in;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            step_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (press) begin
                        press_q <= 1'b1;
                        step_q  <= 1'b1;
                        state_q <= PRESSED;
                    end
                end
                PRESSED: begin
                    if (!btn_in) begin
                        release_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_key_repeater.sv
// tb_key_repeater: scoreboard bench with a hold-length reference model.
// Follows KEY_REPEATER_AUTOREPEAT_EN in the same way as the design.
module tb_key_repeater;

    localparam int HOLD = 8;
    localparam int REP  = 4;

`ifdef KEY_REPEATER_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_a_p = 1'b1;
    logic btn_in = 1'b0;
    logic press_pulse, release_pulse, step_pulse, held;

    int total = 0;
    int bad = 0;

    // Expected {press, release, step, held} after each rising edge.
    logic [3:0] exp_q[$];

    // Model state: last sampled level and edges held since the press.
    bit m_prev = 1'b0;
    int m_h = -1;

    key_repeater #(
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk          (clk),
        .rst_a_p      (rst_a_p),
        .btn_in       (btn_in),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .step_pulse   (step_pulse),
        .held         (held)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic act, logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t actual=%b required=%b",
                     name, $time, act, req);
        end
    endtask

    // Drive one cycle of inputs and queue what the next edge must yield.
    task automatic drive(bit b, bit r);
        bit p, rl, s, hd;
        @(negedge clk);
        btn_in  = b;
        rst_a_p = r;
        if (r) begin
            {p, rl, s, hd} = 4'b0000;
            m_prev = 1'b0;
            m_h = -1;
        end else begin
            p  = b && !m_prev;
            rl = !b && m_prev;
            if (!b)     m_h = -1;
            else if (p) m_h = 0;
            else        m_h = m_h + 1;
            s  = b && (m_h == 0 || (AUTO && m_h >= HOLD &&
                       (m_h - HOLD) % REP == 0));
            hd = AUTO && b && m_h >= HOLD;
            m_prev = b;
        end
        exp_q.push_back({p, rl, s, hd});
    endtask

    task automatic run(bit b, int n);
        for (int i = 0; i < n; i++) drive(b, 1'b0);
    endtask

    // Monitor: compare every edge's registered outputs with the queue.
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("press_pulse",   press_pulse,   e[3]);
                chk("release_pulse", release_pulse, e[2]);
                chk("step_pulse",    step_pulse,    e[1]);
                chk("held",          held,          e[0]);
            end
        end
    end

    initial begin
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        run(1'b0, 3);
        // Long hold: press step, then repeats after hold/repeat periods.
        run(1'b1, 20);
        run(1'b0, 3);
        // Short hold: press and release only.
        run(1'b1, 5);
        run(1'b0, 3);
        // Release exactly on the hold terminal edge.
        run(1'b1, 8);
        run(1'b0, 3);
        // Reset mid-hold, button still down: fresh press afterwards.
        run(1'b1, 10);
        drive(1'b1, 1'b1);
        run(1'b1, 12);
        run(1'b0, 2);
        // Release on a repeat terminal edge.
        run(1'b1, 12);
        run(1'b0, 2);
        // Long hold for the no-repeat build.
        run(1'b1, 30);
        run(1'b0, 2);
        // Randomized runs with occasional resets.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) == 0)
                drive(1'($urandom_range(0, 1)), 1'b1);
            run(1'($urandom_range(0, 1)), $urandom_range(1, 25));
        end
        run(1'b0, 2);
        @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_repeater.md
KEY_REPEATER -- requirements
Module: key_repeater

Interface
REQ-001 Parameter HOLD_CYCLES, default 50_000_000: cycles from press pulse to first auto-repeat step; legal range >= 2.
REQ-002 Parameter REPEAT_CYCLES, default 10_000_000: cycles between successive auto-repeat steps; legal range >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_a_p  input  1  reset; synchronous, active-high; sampled only on the rising edge of clk.
REQ-005 btn_in  input  1  debounced button level from the debouncer stage; 1 = pressed; already synchronous to clk.
REQ-006 press_pulse  output  1  one-cycle pulse on the press (0->1) of btn_in.
REQ-007 release_pulse  output  1  one-cycle pulse on the release (1->0) of btn_in.
REQ-008 step_pulse  output  1  one-cycle pulse per press plus one per auto-repeat; drives the up/down counter enable.
REQ-009 held  output  1  level; 1 while in REPEAT state.

Function
REQ-010 All outputs registered; no combinational path from btn_in to any output.
REQ-011 Internal btn_q holds btn_in from the previous edge; press = btn_in & ~btn_q, release = ~btn_in & btn_q.
REQ-012 FSM states: IDLE, PRESSED, REPEAT; single counter cnt, width $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)).
REQ-013 Latency: btn_in first sampled 1 at edge E0 -> press_pulse=1 and step_pulse=1 for the cycle after E0; FSM enters PRESSED, cnt=0.
REQ-014 PRESSED: cnt increments each edge while btn_in=1; at the edge where cnt==HOLD_CYCLES-1, step_pulse=1 for one cycle, FSM -> REPEAT, cnt=0, held=1.
REQ-015 REPEAT: cnt increments each edge while btn_in=1; at the edge where cnt==REPEAT_CYCLES-1, step_pulse=1 for one cycle, cnt=0, FSM stays REPEAT.
REQ-016 First auto-repeat step occurs exactly HOLD_CYCLES cycles after the press step; subsequent steps every REPEAT_CYCLES cycles.
REQ-017 btn_in sampled 0 in PRESSED or REPEAT -> release_pulse=1 for one cycle, FSM -> IDLE, cnt=0, held=0, no step_pulse.
REQ-018 Release and counter terminal on the same edge: release wins; no step_pulse.
REQ-019 Press and release pulses are never high in the same cycle; press_pulse never asserted outside IDLE->PRESSED transition.
REQ-020 IDLE: cnt held at 0; step_pulse only via press.
REQ-021 cnt never exceeds its terminal value; no wrap-around beyond terminal.

Reset
REQ-022 rst_a_p=1 at an edge: FSM=IDLE, cnt=0, btn_q=0, press_pulse=0, release_pulse=0, step_pulse=0, held=0.
REQ-023 Reset mid-press overrides all else; after reset deassertion with btn_in still 1, the next edge produces a fresh press_pulse and step_pulse (btn_q=0 treats level as new press).
REQ-024 Reset asserted in the same cycle as a press or terminal count: no pulse output.

Configuration
REQ-025 Macro KEY_REPEATER_AUTOREPEAT_EN defined: REPEAT state and auto-repeat steps present as in REQ-014..016.
REQ-026 Macro KEY_REPEATER_AUTOREPEAT_EN undefined: no REPEAT state or counter; step_pulse only on press; held constant 0; press_pulse/release_pulse unchanged.

Verification (HOLD_CYCLES=8, REPEAT_CYCLES=4, macro defined unless stated)
REQ-027 btn_in 0->1 sampled at E0, held 20 cycles -> press_pulse and step_pulse high cycle after E0; further step_pulse after E8, E12, E16; held=1 from after E8.
REQ-028 btn_in high for 5 cycles then low -> one press_pulse, one step_pulse, one release_pulse after the release edge; held stays 0.
REQ-029 Release sampled exactly at E8 (terminal edge) -> release_pulse=1, step_pulse=0, FSM IDLE.
REQ-030 rst_a_p pulsed 1 cycle at E10 with btn_in held 1 -> all outputs 0 after E10; press_pulse and step_pulse high after E11; next repeat after E19.
REQ-031 Macro undefined, btn_in held 30 cycles -> exactly one step_pulse; held=0 throughout; one release_pulse at release.
